// File: rtl/shift_reg_checker.sv
// Shadow-model checker for a universal shift register: mirrors the register
// from its control inputs and flags any disagreement on q or s_out.
module shift_reg_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  input  logic             s_out,
  input  logic             clear,
  output logic             synced,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_q,
  output logic [WIDTH-1:0] first_err_exp
);

  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             ms_q, ms_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] feq_q, feq_d;
  logic [WIDTH-1:0] fee_q, fee_d;
  logic             mismatch;

  assign mismatch = (q != m_q) || (s_out != ms_q);

  // Reference model update; independent of sync state.
  always_comb begin
    m_d  = m_q;
    ms_d = ms_q;
    if (enb) begin
      case (mode)
        MODE_SHIFT: begin
          if (dir) begin
            m_d  = {s_in, m_q[WIDTH-1:1]};
            ms_d = m_q[0];
          end else begin
            m_d  = {m_q[WIDTH-2:0], s_in};
            ms_d = m_q[WIDTH-1];
          end
        end
        MODE_ROTATE: begin
          if (dir) begin
            m_d  = {m_q[0], m_q[WIDTH-1:1]};
            ms_d = m_q[0];
          end else begin
            m_d  = {m_q[WIDTH-2:0], m_q[WIDTH-1]};
            ms_d = m_q[WIDTH-1];
          end
        end
        MODE_LOAD: begin
          m_d  = d;
          ms_d = 1'b0;
        end
        default: begin
          m_d  = m_q;
          ms_d = ms_q;
        end
      endcase
    end
  end

  // Sync FSM and error bookkeeping; compares use pre-update model values.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    feq_d   = feq_q;
    fee_d   = fee_q;
    if (clear) begin
      state_d = UNSYNC;
      cnt_d   = '0;
      feq_d   = '0;
      fee_d   = '0;
    end else begin
      case (state_q)
        UNSYNC: begin
          if (enb && (mode == MODE_LOAD)) begin
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == '0) begin
              feq_d = q;
              fee_d = m_q;
            end
          end
        end
        default: state_d = UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= UNSYNC;
      m_q     <= '0;
      ms_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      feq_q   <= '0;
      fee_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      ms_q    <= ms_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      feq_q   <= feq_d;
      fee_q   <= fee_d;
    end
  end

  assign synced        = (state_q == SYNC);
  assign err           = err_q;
  assign err_count     = cnt_q;
  assign first_err_q   = feq_q;
  assign first_err_exp = fee_q;

endmodule
